// File: rtl/pixel_map_stream.sv
// Raster-order pixel to complex-plane coordinate mapper on a valid/ready stream.
// Optional back-to-back frames when PIXEL_MAP_CONTINUOUS_EN is defined.

module pixel_map_stream_chk #(
    parameter int PIXEL_WIDTH = 10,
    parameter int DATA_WIDTH  = 25
) (
    input logic                   clk,
    input logic                   reset,
    input logic                   out_valid_o,
    input logic                   out_ready_i,
    input logic                   busy_o,
    input logic [DATA_WIDTH-1:0]  real_x_o,
    input logic [DATA_WIDTH-1:0]  imag_y_o,
    input logic [PIXEL_WIDTH-1:0] pixel_x_o,
    input logic [PIXEL_WIDTH-1:0] pixel_y_o
);
    // A stalled beat must stay valid and stable until it is taken.
    a_hold: assert property (@(posedge clk) disable iff (reset)
        (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(real_x_o) &&
        $stable(imag_y_o) && $stable(pixel_x_o) && $stable(pixel_y_o)));

    a_busy: assert property (@(posedge clk) disable iff (reset)
        out_valid_o |-> busy_o);
endmodule

module pixel_map_stream #(
    parameter int PIXEL_WIDTH = 10,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int DATA_WIDTH  = 25,
    parameter int FRACT_WIDTH = 20,
    parameter int ZOOM_WIDTH  = 3,
    parameter int R_MIN_BASE  = -2097152,
    parameter int I_MIN_BASE  = -1572864,
    parameter int STEP_BASE   = 6554
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [ZOOM_WIDTH-1:0]  zoom_i,
    input  logic [DATA_WIDTH-1:0]  x_offset_i,
    input  logic [DATA_WIDTH-1:0]  y_offset_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_WIDTH-1:0]  real_x_o,
    output logic [DATA_WIDTH-1:0]  imag_y_o,
    output logic [PIXEL_WIDTH-1:0] pixel_x_o,
    output logic [PIXEL_WIDTH-1:0] pixel_y_o,
    output logic                   line_end_o,
    output logic                   frame_end_o,
    output logic                   busy_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [PIXEL_WIDTH-1:0]       X_LAST  = PIXEL_WIDTH'(SCREEN_W - 1);
    localparam logic [PIXEL_WIDTH-1:0]       Y_LAST  = PIXEL_WIDTH'(SCREEN_H - 1);
    localparam logic [DATA_WIDTH-1:0]        STEP_C  = DATA_WIDTH'(STEP_BASE);
    localparam logic signed [DATA_WIDTH-1:0] R_MIN_C = DATA_WIDTH'(R_MIN_BASE);
    localparam logic signed [DATA_WIDTH-1:0] I_MIN_C = DATA_WIDTH'(I_MIN_BASE);

    logic [1:0]             state_q, state_d;
    logic [ZOOM_WIDTH-1:0]  zoom_q, zoom_d;
    logic [DATA_WIDTH-1:0]  x_off_q, x_off_d;
    logic [DATA_WIDTH-1:0]  y_off_q, y_off_d;
    logic [DATA_WIDTH-1:0]  step_q, step_d;
    logic [DATA_WIDTH-1:0]  r_min_q, r_min_d;
    logic [DATA_WIDTH-1:0]  real_q, real_d;
    logic [DATA_WIDTH-1:0]  imag_q, imag_d;
    logic [PIXEL_WIDTH-1:0] px_q, px_d;
    logic [PIXEL_WIDTH-1:0] py_q, py_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;

    // Shifted bases must be held in signed variables so >>> stays arithmetic.
    logic signed [DATA_WIDTH-1:0] r_shift_s;
    logic signed [DATA_WIDTH-1:0] i_shift_s;
    logic                         xfer_s;
    logic                         line_end_s;

    // Frame constants derived from the latched zoom level.
    always_comb begin
        r_shift_s = R_MIN_C >>> zoom_q;
        i_shift_s = I_MIN_C >>> zoom_q;
    end

    // Handshake and raster position decode.
    always_comb begin
        xfer_s      = valid_q & out_ready_i;
        line_end_s  = (px_q == X_LAST);
        line_end_o  = line_end_s;
        frame_end_o = line_end_s & (py_q == Y_LAST);
    end

    // Next-state logic for the frame FSM and the incremental coordinate datapath.
    always_comb begin
        state_d = state_q;
        zoom_d  = zoom_q;
        x_off_d = x_off_q;
        y_off_d = y_off_q;
        step_d  = step_q;
        r_min_d = r_min_q;
        real_d  = real_q;
        imag_d  = imag_q;
        px_d    = px_q;
        py_d    = py_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    zoom_d  = zoom_i;
                    x_off_d = x_offset_i;
                    y_off_d = y_offset_i;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                step_d  = STEP_C >> zoom_q;
                r_min_d = x_off_q + r_shift_s;
                real_d  = x_off_q + r_shift_s;
                imag_d  = y_off_q + i_shift_s;
                px_d    = {PIXEL_WIDTH{1'b0}};
                py_d    = {PIXEL_WIDTH{1'b0}};
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (xfer_s) begin
                    if (!line_end_s) begin
                        px_d   = px_q + PIXEL_WIDTH'(1);
                        real_d = real_q + step_q;
                    end else begin
                        px_d   = {PIXEL_WIDTH{1'b0}};
                        real_d = r_min_q;
                        if (py_q != Y_LAST) begin
                            py_d   = py_q + PIXEL_WIDTH'(1);
                            imag_d = imag_q + step_q;
                        end else begin
`ifdef PIXEL_MAP_CONTINUOUS_EN
                            zoom_d  = zoom_i;
                            x_off_d = x_offset_i;
                            y_off_d = y_offset_i;
                            state_d = ST_LOAD;
`else
                            state_d = ST_IDLE;
`endif
                        end
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        valid_d = (state_d == ST_RUN);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            zoom_q  <= {ZOOM_WIDTH{1'b0}};
            x_off_q <= {DATA_WIDTH{1'b0}};
            y_off_q <= {DATA_WIDTH{1'b0}};
            step_q  <= {DATA_WIDTH{1'b0}};
            r_min_q <= {DATA_WIDTH{1'b0}};
            real_q  <= {DATA_WIDTH{1'b0}};
            imag_q  <= {DATA_WIDTH{1'b0}};
            px_q    <= {PIXEL_WIDTH{1'b0}};
            py_q    <= {PIXEL_WIDTH{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            zoom_q  <= zoom_d;
            x_off_q <= x_off_d;
            y_off_q <= y_off_d;
            step_q  <= step_d;
            r_min_q <= r_min_d;
            real_q  <= real_d;
            imag_q  <= imag_d;
            px_q    <= px_d;
            py_q    <= py_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign out_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign real_x_o    = real_q;
    assign imag_y_o    = imag_q;
    assign pixel_x_o   = px_q;
    assign pixel_y_o   = py_q;

    pixel_map_stream_chk #(
        .PIXEL_WIDTH(PIXEL_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .busy_o     (busy_o),
        .real_x_o   (real_x_o),
        .imag_y_o   (imag_y_o),
        .pixel_x_o  (pixel_x_o),
        .pixel_y_o  (pixel_y_o)
    );
endmodule

// File: doc/pixel_map_stream.md
# pixel_map_stream

Frame-level pixel-to-complex-plane mapper for the fractal engine front end. On `start` it latches zoom and offset, then emits every pixel of a SCREEN_W × SCREEN_H frame in raster order. Each pixel carries its fixed-point real/imaginary coordinate and is sent on a valid/ready stream to the distributor. Coordinates are computed incrementally with adders, so the block needs no multipliers. Zoom depth, screen size and number format are all parametrised.

## Interface
- `PIXEL_WIDTH`, 10, width of pixel coordinate outputs.
- `SCREEN_W`, 640, pixels per line (≤ 2^PIXEL_WIDTH).
- `SCREEN_H`, 480, lines per frame (≤ 2^PIXEL_WIDTH).
- `DATA_WIDTH`, 25, signed two's-complement coordinate width.
- `FRACT_WIDTH`, 20, fractional bits of the coordinate format.
- `ZOOM_WIDTH`, 3, zoom levels 0 .. 2^ZOOM_WIDTH−1.
- `R_MIN_BASE`, −2097152, left edge at zoom 0 (−2.0).
- `I_MIN_BASE`, −1572864, top edge at zoom 0 (−1.5).
- `STEP_BASE`, 6554, per-pixel increment at zoom 0 (≈3.0/480).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: frame request pulse; honoured only in IDLE.
- `zoom` in ZOOM_WIDTH: zoom level, sampled on an accepted start.
- `x_offset` in DATA_WIDTH: signed real offset, sampled on an accepted start.
- `y_offset` in DATA_WIDTH: signed imaginary offset, sampled on an accepted start.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts the beat.
- `real_x` out DATA_WIDTH: signed real coordinate of the beat.
- `imag_y` out DATA_WIDTH: signed imaginary coordinate of the beat.
- `pixel_x` out PIXEL_WIDTH: pixel column of the beat.
- `pixel_y` out PIXEL_WIDTH: pixel row of the beat.
- `line_end` out 1: beat is the last pixel of its line.
- `frame_end` out 1: beat is the last pixel of the frame.
- `busy` out 1: asserted in any state other than IDLE.

## Operation
- Three states: IDLE, LOAD, RUN.
- IDLE:
  - `busy`=0, `out_valid`=0.
  - When `start`=1: latch zoom z and both offsets, then go to LOAD.
- LOAD (one cycle) registers the frame constants:
  - step = STEP_BASE >> z (logical).
  - r_min = x_offset + (R_MIN_BASE >>> z).
  - i_min = y_offset + (I_MIN_BASE >>> z).
  - It then sets pixel_x=0, pixel_y=0, real_x=r_min, imag_y=i_min, and goes to RUN.
- RUN holds `out_valid`=1. On each transfer (`out_valid` & `out_ready`):
  - If pixel_x < SCREEN_W−1: pixel_x+1, real_x += step.
  - Otherwise: pixel_x=0, real_x=r_min, and:
    - if pixel_y < SCREEN_H−1: pixel_y+1, imag_y += step;
    - otherwise the frame is done; go to IDLE (or to LOAD, see Configuration).
- Output relations:
  - `line_end` = (pixel_x == SCREEN_W−1).
  - `frame_end` = `line_end` & (pixel_y == SCREEN_H−1).
  - Both are combinational from registered state and valid only with `out_valid`.
- Arithmetic:
  - All adds are DATA_WIDTH wide and wrap modulo 2^DATA_WIDTH; there is no saturation.
  - The accumulated result equals r_min + pixel_x·step exactly, with no drift.
- `start` in LOAD or RUN is ignored. Input changes after latching have no effect until the next accepted start.

## Timing
- Reset values: `out_valid`=0, `busy`=0, `real_x`=0, `imag_y`=0, `pixel_x`=0, `pixel_y`=0, state=IDLE.
- Reset mid-frame aborts the frame; outputs return to reset values on the next edge.
- Latency: `start` sampled at edge N → LOAD during cycle N+1 → first beat valid from edge N+2.
- Throughput: one pixel per clock while `out_ready`=1.
- Handshake:
  - While `out_valid` & !`out_ready`, all outputs hold stable.
  - `out_valid` never drops without a transfer, except on reset.
- After the frame_end transfer at edge M, `out_valid`=0 and `busy`=0 from edge M. A new `start` is accepted from cycle M onward.

## Configuration
- `PIXEL_MAP_CONTINUOUS_EN`
  - Defined: after the frame_end transfer the FSM goes directly to LOAD. It re-samples `zoom`, `x_offset` and `y_offset` in that same transfer cycle and starts the next frame. There is exactly one bubble cycle (`out_valid`=0 in LOAD), `busy` stays 1, and `start` is ignored.
  - Undefined: the FSM returns to IDLE and waits for `start`.

## Test plan
- Zoom 0, default parameters, offsets 0:
  - Beat (0,0) → real −2097152, imag −1572864.
  - Beat (639,0) → real 2090854.
  - Beat (0,479) → imag 1566502.
- Zoom 3, x_offset 1048576 → step 819.
  - Beat (0,0) → real 786432.
  - Beat (10,0) → real 794622.
  - Beat (0,0) → imag −196608.
- SCREEN_W=4, SCREEN_H=3, `out_ready` tied 1:
  - Exactly 12 transfers occur.
  - `line_end` on beats 4, 8 and 12; `frame_end` only on beat 12.
  - `out_valid` first rises two cycles after `start`.
- Backpressure: drop `out_ready` for 5 cycles at pixel (5,2) → outputs unchanged throughout; the next accepted beat is (6,2); no pixel is skipped or repeated.
- `start` pulses while busy, with zoom changed mid-frame → no restart; all coordinates still use the originally latched zoom.
- Reset asserted at pixel (100,50) → `out_valid`=0 next cycle. A new `start` produces (0,0) again two cycles later.
- With `PIXEL_MAP_CONTINUOUS_EN` defined, after the frame_end beat → exactly one idle cycle, then (0,0) of the next frame using the newly sampled zoom.
